piso_ser_ctrl: RTL

//   Controller plus datapath that serializes parallel words onto a 1-bit stream.
//   It accepts a WIDTH-bit word on a valid/ready handshake and loads it into an

---
 rtl/piso_ser_ctrl.sv | 86 ++++++++
 1 files changed

// File: rtl/piso_ser_ctrl.sv
// Parallel-in/serial-out controller: accepts a word on a valid/ready handshake
// and streams it out one bit per serial beat, flagging the last bit of each word.
module piso_ser_ctrl #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     ser_valid,
    input  logic                     ser_ready,
    output logic                     ser_data,
    output logic                     ser_last,
    output logic                     busy,
    output logic [$clog2(WIDTH)-1:0] bit_cnt
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_bit;
    logic             beat;
    logic             load;

    always_comb begin
        busy      = (state_q == SHIFT);
        ser_valid = busy;
        out_bit   = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
        ser_data  = busy & out_bit;
        ser_last  = busy && (cnt_q == LAST_IDX);
        bit_cnt   = cnt_q;
        beat      = ser_valid & ser_ready;
        // A new word may enter on the last-bit beat so words stream without a bubble.
        in_ready  = !flush && (!busy || (ser_last && ser_ready));
        load      = in_valid & in_ready;
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = IDLE;
            shift_d = '0;
            cnt_d   = '0;
        end else if (load) begin
            state_d = SHIFT;
            shift_d = in_data;
            cnt_d   = '0;
        end else if (beat) begin
            if (ser_last) begin
                state_d = IDLE;
                shift_d = '0;
                cnt_d   = '0;
            end else begin
                shift_d = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, shift_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
